// File: rtl/stl_wb_arbiter.sv
// rtl/stl_wb_arbiter.sv - round-robin writeback arbiter with burst lock for the GPR write port
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_hold                 pipeline hold, suppresses every grant
//   i_req_valid[NREQ]      per-requester write request
//   i_req_lock[NREQ]       requester keeps the port after this grant
//   i_req_addr[NREQ*AW]    packed addresses, requester k at [k*AW +: AW]
//   i_req_data[NREQ*DW]    packed data, requester k at [k*DW +: DW]
//   o_req_ready[NREQ]      one-hot combinational grant
//   o_rf_wen/waddr/wdata   registered register-file write port
//   o_owner[NREQ]          registered one-hot lock owner, 0 when free
module stl_wb_arbiter #(
  parameter int NREQ      = 3,
  parameter int AW        = 5,
  parameter int DW        = 64,
  parameter int ZERO_DROP = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_hold,
  input  logic [NREQ-1:0]    i_req_valid,
  input  logic [NREQ-1:0]    i_req_lock,
  input  logic [NREQ*AW-1:0] i_req_addr,
  input  logic [NREQ*DW-1:0] i_req_data,
  output logic [NREQ-1:0]    o_req_ready,
  output logic               o_rf_wen,
  output logic [AW-1:0]      o_rf_waddr,
  output logic [DW-1:0]      o_rf_wdata,
  output logic [NREQ-1:0]    o_owner
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = PW + 1;

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   owner_q, owner_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic              wen_q, wen_d;
  logic [AW-1:0]     waddr_q, waddr_d;
  logic [DW-1:0]     wdata_q, wdata_d;

  logic [NREQ-1:0]   gnt_free;
  logic [NREQ-1:0]   gnt;
  logic [IW-1:0]     idx;
  logic              found;
  logic              xfer;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     ptr_inc;
  logic              win_lock;
  logic [AW-1:0]     win_addr;
  logic [DW-1:0]     win_data;
  logic              drop;

  // Rotating priority search: walk from the pointer upward, wrapping at NREQ,
  // and take the first valid requester.
  always_comb begin
    gnt_free = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr_q} + IW'(i);
      if (idx >= IW'(NREQ)) begin
        idx = idx - IW'(NREQ);
      end
      if (!found && i_req_valid[idx[PW-1:0]]) begin
        gnt_free[idx[PW-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

  // While locked only the owner may transfer; other requesters see no ready
  // even if the owner is idle.
  always_comb begin
    gnt = '0;
    if (!i_hold) begin
      if (state_q == ST_LOCKED) begin
        gnt = owner_q & i_req_valid;
      end else begin
        gnt = gnt_free;
      end
    end
  end

  assign o_req_ready = gnt;
  assign xfer        = |gnt;

  // Steer the single granted requester's lock, address and data.
  always_comb begin
    win_idx  = '0;
    win_lock = 1'b0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_idx  = PW'(i);
        win_lock = i_req_lock[i];
        win_addr = i_req_addr[i*AW +: AW];
        win_data = i_req_data[i*DW +: DW];
      end
    end
  end

  assign ptr_inc = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
  assign drop    = (ZERO_DROP != 0) && (win_addr == '0);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (xfer) begin
      if (state_q == ST_FREE) begin
        ptr_d = ptr_inc;
        if (win_lock) begin
          state_d = ST_LOCKED;
          owner_d = gnt;
        end
      end else if (!win_lock) begin
        // The last beat of a burst still transfers; the pointer then moves
        // past the owner so the others get the next turn.
        state_d = ST_FREE;
        owner_d = '0;
        ptr_d   = ptr_inc;
      end
      // A write to register 0 is accepted but never reaches the file, and
      // the port keeps showing the previous address and data.
      if (!drop) begin
        wen_d   = 1'b1;
        waddr_d = win_addr;
        wdata_d = win_data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_FREE;
      owner_q <= '0;
      ptr_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign o_rf_wen   = wen_q;
  assign o_rf_waddr = waddr_q;
  assign o_rf_wdata = wdata_q;
  assign o_owner    = owner_q;

endmodule

// File: tb/tb_stl_wb_arbiter.sv
// tb/tb_stl_wb_arbiter.sv - self-checking bench for stl_wb_arbiter
module tb_stl_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 64;

  logic            clk;
  logic            rst_n;
  logic            hold;
  logic [N-1:0]    valid;
  logic [N-1:0]    lock;
  logic [N*AW-1:0] addr_bus;
  logic [N*DW-1:0] data_bus;
  logic [N-1:0]    ready;
  logic            rf_wen;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic [N-1:0]    owner;

  stl_wb_arbiter #(.NREQ(N), .AW(AW), .DW(DW), .ZERO_DROP(1)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_hold      (hold),
    .i_req_valid (valid),
    .i_req_lock  (lock),
    .i_req_addr  (addr_bus),
    .i_req_data  (data_bus),
    .o_req_ready (ready),
    .o_rf_wen    (rf_wen),
    .o_rf_waddr  (rf_waddr),
    .o_rf_wdata  (rf_wdata),
    .o_owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] req_addr [N];
  logic [DW-1:0] req_data [N];

  // Reference model: round-robin pointer, lock flag/owner, expected write port.
  int            m_ptr;
  bit            m_locked;
  int            m_owner;
  logic          exp_wen;
  logic [AW-1:0] exp_waddr;
  logic [DW-1:0] exp_wdata;
  logic [N-1:0]  last_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr     = 0;
    m_locked  = 0;
    m_owner   = 0;
    exp_wen   = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
  endtask

  function automatic int model_grant(input logic [N-1:0] v, input logic hd);
    if (hd) return -1;
    if (m_locked) return v[m_owner] ? m_owner : -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[k] = a;
    req_data[k] = d;
  endtask

  // One arbitration cycle: drive, check ready against the model, clock,
  // advance the model, then check the registered port.
  task automatic step(input string tag, input logic [N-1:0] v, input logic [N-1:0] lk, input logic hd);
    int g;
    logic [N-1:0] exp_ready;
    @(negedge clk);
    valid = v;
    lock  = lk;
    hold  = hd;
    for (int k = 0; k < N; k++) begin
      addr_bus[k*AW +: AW] = req_addr[k];
      data_bus[k*DW +: DW] = req_data[k];
    end
    #1;
    g = model_grant(v, hd);
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    last_ready = ready;
    chk({tag, "_ready"}, 64'(ready), 64'(exp_ready));
    @(posedge clk);
    #1;
    exp_wen = 1'b0;
    if (g >= 0) begin
      if (!m_locked) begin
        m_ptr = (g + 1) % N;
        if (lk[g]) begin
          m_locked = 1;
          m_owner  = g;
        end
      end else if (!lk[g]) begin
        m_locked = 0;
        m_ptr    = (g + 1) % N;
      end
      if (req_addr[g] != 0) begin
        exp_wen   = 1'b1;
        exp_waddr = req_addr[g];
        exp_wdata = req_data[g];
      end
    end
    chk({tag, "_wen"},   64'(rf_wen),   64'(exp_wen));
    chk({tag, "_waddr"}, 64'(rf_waddr), 64'(exp_waddr));
    chk({tag, "_wdata"}, rf_wdata,      exp_wdata);
    chk({tag, "_owner"}, 64'(owner),    m_locked ? 64'(1 << m_owner) : 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    hold     = 1'b0;
    valid    = '0;
    lock     = '0;
    addr_bus = '0;
    data_bus = '0;
    model_reset();
    set_req(0, 5'd1, 64'hA);
    set_req(1, 5'd2, 64'hB);
    set_req(2, 5'd3, 64'hC);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wen",   64'(rf_wen),   64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_wdata", rf_wdata,      64'd0);
    chk("rst_owner", 64'(owner),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Round robin over three always-valid requesters.
    step("t1a", 3'b111, 3'b000, 1'b0); chk("t1a_lit", 64'(last_ready), 64'b001); chk("t1a_la", 64'(rf_waddr), 64'd1);
    step("t1b", 3'b111, 3'b000, 1'b0); chk("t1b_lit", 64'(last_ready), 64'b010); chk("t1b_la", 64'(rf_waddr), 64'd2);
    step("t1c", 3'b111, 3'b000, 1'b0); chk("t1c_lit", 64'(last_ready), 64'b100); chk("t1c_la", 64'(rf_waddr), 64'd3);
    step("t1d", 3'b111, 3'b000, 1'b0); chk("t1d_lit", 64'(last_ready), 64'b001); chk("t1d_la", 64'(rf_waddr), 64'd1);

    // Requester 1 holds the port for a three-beat burst.
    set_req(1, 5'd4, 64'h11);
    step("t2a", 3'b111, 3'b010, 1'b0); chk("t2a_lit", 64'(last_ready), 64'b010); chk("t2a_own", 64'(owner), 64'b010);
    set_req(1, 5'd5, 64'h12);
    step("t2b", 3'b111, 3'b010, 1'b0); chk("t2b_lit", 64'(last_ready), 64'b010); chk("t2b_own", 64'(owner), 64'b010);
    set_req(1, 5'd6, 64'h13);
    step("t2c", 3'b111, 3'b000, 1'b0); chk("t2c_lit", 64'(last_ready), 64'b010); chk("t2c_own", 64'(owner), 64'b000);
    set_req(1, 5'd2, 64'hB);
    step("t2d", 3'b111, 3'b000, 1'b0); chk("t2d_lit", 64'(last_ready), 64'b100);
    step("t2e", 3'b111, 3'b000, 1'b0); chk("t2e_lit", 64'(last_ready), 64'b001);

    // Write to register 0 is accepted, not forwarded; pointer still advances.
    set_req(0, 5'd0, 64'hFF);
    step("t3a", 3'b001, 3'b000, 1'b0); chk("t3a_lit", 64'(last_ready), 64'b001); chk("t3a_wen", 64'(rf_wen), 64'd0);
    chk("t3a_held", 64'(rf_waddr), 64'd1);
    set_req(0, 5'd1, 64'hA);
    step("t3b", 3'b111, 3'b000, 1'b0); chk("t3b_lit", 64'(last_ready), 64'b010);

    // Hold freezes arbitration for two cycles.
    step("t4a", 3'b111, 3'b000, 1'b1); chk("t4a_lit", 64'(last_ready), 64'b000); chk("t4a_wen", 64'(rf_wen), 64'd0);
    step("t4b", 3'b111, 3'b000, 1'b1); chk("t4b_lit", 64'(last_ready), 64'b000); chk("t4b_wen", 64'(rf_wen), 64'd0);
    step("t4c", 3'b111, 3'b000, 1'b0); chk("t4c_lit", 64'(last_ready), 64'b100);

    // Asynchronous reset while locked with a write pending.
    step("t5a", 3'b111, 3'b001, 1'b0); chk("t5a_lit", 64'(last_ready), 64'b001); chk("t5a_own", 64'(owner), 64'b001);
    step("t5b", 3'b111, 3'b001, 1'b0); chk("t5b_pend", 64'(rf_wen), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_wen",   64'(rf_wen),   64'd0);
    chk("t5_rst_owner", 64'(owner),    64'd0);
    chk("t5_rst_waddr", 64'(rf_waddr), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("t5c", 3'b111, 3'b000, 1'b0); chk("t5c_lit", 64'(last_ready), 64'b001);

    // Lone request from requester 2 wraps the pointer to 0.
    set_req(2, 5'd7, 64'h77);
    step("t6a", 3'b100, 3'b000, 1'b0); chk("t6a_lit", 64'(last_ready), 64'b100);
    chk("t6a_wen", 64'(rf_wen), 64'd1); chk("t6a_waddr", 64'(rf_waddr), 64'd7); chk("t6a_wdata", rf_wdata, 64'h77);
    step("t6b", 3'b111, 3'b000, 1'b0); chk("t6b_lit", 64'(last_ready), 64'b001);
    step("t6c", 3'b000, 3'b000, 1'b0); chk("t6c_wen", 64'(rf_wen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
